// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access arbiter: register address map, update indices
// and FSM state encoding.
package rtc_pkg;

   localparam logic [7:0] CMD_ADDR_DEF = 8'hF0;
   localparam logic [7:0] CMD_DATA_DEF = 8'hF0;
   localparam int         NUM_REGS     = 9;

   // RTC address of each register refreshed by a burst, in upd_sel order.
   localparam logic [7:0] ADDR_TABLE [0:NUM_REGS-1] = '{
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43
   };

   typedef enum logic [3:0] {
      SEL_SEG        = 4'd0,
      SEL_MIN        = 4'd1,
      SEL_HORA       = 4'd2,
      SEL_DIA        = 4'd3,
      SEL_MES        = 4'd4,
      SEL_JAHR       = 4'd5,
      SEL_SEG_TIMER  = 4'd6,
      SEL_MIN_TIMER  = 4'd7,
      SEL_HORA_TIMER = 4'd8
   } upd_sel_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WR_ISSUE  = 3'd1,
      ST_WR_WAIT   = 3'd2,
      ST_LAT_ISSUE = 3'd3,
      ST_LAT_WAIT  = 3'd4,
      ST_RD_ISSUE  = 3'd5,
      ST_RD_WAIT   = 3'd6
   } estado_t;

   function automatic logic [7:0] reg_addr(input logic [3:0] idx);
      return (idx <= SEL_HORA_TIMER) ? ADDR_TABLE[idx] : 8'h00;
   endfunction

endpackage

// File: rtl/contador_timeout_rtc.sv
// Wait-cycle counter for one RTC transaction: cleared while issuing, counts while waiting,
// flags expiry at TIMEOUT_CYC-1 and holds there.
module contador_timeout_rtc #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CW-1:0] cnt;

   assign expired = (cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/arbitro_acceso_rtc.sv
// Arbiter in front of the RTC bus transaction engine: PicoBlaze single writes and periodic
// refresh bursts (latch command plus 9 register reads streamed to the VGA register bank).
module arbitro_acceso_rtc
   import rtc_pkg::*;
#(
   parameter logic [7:0] CMD_ADDR    = CMD_ADDR_DEF,
   parameter logic [7:0] CMD_DATA    = CMD_DATA_DEF,
   parameter int         TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_refresh,
   input  logic       pb_req,
   input  logic [7:0] pb_addr,
   input  logic [7:0] pb_data,
   output logic       pb_busy,
   output logic       rtc_req,
   output logic       rtc_we,
   output logic [7:0] rtc_addr,
   output logic [7:0] rtc_wdata,
   input  logic       rtc_done,
   input  logic [7:0] rtc_rdata,
   output logic       upd_valid,
   output logic [3:0] upd_sel,
   output logic [7:0] upd_data,
   output logic       burst_active,
   output logic       err_timeout,
   output logic       err_overrun,
   input  logic       clr_err
);
   estado_t    state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic       wr_pend, ref_pend, gap_q;
   logic [7:0] buf_addr, buf_data;
   logic       burst_d, we_d;
   logic [7:0] addr_d, wdata_d;
   logic       in_issue, in_wait, cnt_expired;
   logic       done_acc, upd_fire, wr_clr, ref_take, timeout_evt;

   assign in_issue = (state_q == ST_WR_ISSUE) || (state_q == ST_LAT_ISSUE) || (state_q == ST_RD_ISSUE);
   assign in_wait  = (state_q == ST_WR_WAIT)  || (state_q == ST_LAT_WAIT)  || (state_q == ST_RD_WAIT);

   // gap_q holds an ISSUE state one extra cycle so the bus always idles after a completion.
   assign rtc_req = in_issue && !gap_q;
   assign pb_busy = wr_pend || (state_q == ST_WR_ISSUE) || (state_q == ST_WR_WAIT);

   contador_timeout_rtc #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (in_issue),
      .en      (in_wait),
      .expired (cnt_expired)
   );

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      state_d     = state_q;
      idx_d       = idx_q;
      burst_d     = burst_active;
      we_d        = rtc_we;
      addr_d      = rtc_addr;
      wdata_d     = rtc_wdata;
      done_acc    = 1'b0;
      upd_fire    = 1'b0;
      wr_clr      = 1'b0;
      ref_take    = 1'b0;
      timeout_evt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_pend) begin
               state_d = ST_WR_ISSUE;
               we_d    = 1'b1;
               addr_d  = buf_addr;
               wdata_d = buf_data;
            end else if (ref_pend) begin
               state_d  = ST_LAT_ISSUE;
               burst_d  = 1'b1;
               ref_take = 1'b1;
               we_d     = 1'b1;
               addr_d   = CMD_ADDR;
               wdata_d  = CMD_DATA;
            end
         end
         ST_WR_ISSUE:  if (!gap_q) state_d = ST_WR_WAIT;
         ST_LAT_ISSUE: if (!gap_q) state_d = ST_LAT_WAIT;
         ST_RD_ISSUE:  if (!gap_q) state_d = ST_RD_WAIT;
         ST_WR_WAIT: begin
            if (rtc_done || cnt_expired) begin
               done_acc    = rtc_done;
               timeout_evt = !rtc_done;
               wr_clr      = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_LAT_WAIT: begin
            if (rtc_done) begin
               done_acc = 1'b1;
               idx_d    = SEL_SEG;
               we_d     = 1'b0;
               addr_d   = reg_addr(SEL_SEG);
               state_d  = ST_RD_ISSUE;
            end else if (cnt_expired) begin
               timeout_evt = 1'b1;
               burst_d     = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            if (rtc_done) begin
               done_acc = 1'b1;
               upd_fire = 1'b1;
               if (idx_q == SEL_HORA_TIMER) begin
                  burst_d = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  addr_d  = reg_addr(idx_q + 4'd1);
                  state_d = ST_RD_ISSUE;
               end
            end else if (cnt_expired) begin
               timeout_evt = 1'b1;
               burst_d     = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         burst_active <= 1'b0;
         rtc_we       <= 1'b0;
         rtc_addr     <= '0;
         rtc_wdata    <= '0;
         gap_q        <= 1'b0;
         upd_valid    <= 1'b0;
         upd_sel      <= '0;
         upd_data     <= '0;
         wr_pend      <= 1'b0;
         buf_addr     <= '0;
         buf_data     <= '0;
         ref_pend     <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         burst_active <= burst_d;
         rtc_we       <= we_d;
         rtc_addr     <= addr_d;
         rtc_wdata    <= wdata_d;
         gap_q        <= done_acc;
         upd_valid    <= upd_fire;
         if (upd_fire) begin
            upd_sel  <= idx_q;
            upd_data <= rtc_rdata;
         end
         // A request arriving while one is buffered is dropped; the buffer keeps the first.
         if (pb_req && !wr_pend) begin
            wr_pend  <= 1'b1;
            buf_addr <= pb_addr;
            buf_data <= pb_data;
         end else if (wr_clr) begin
            wr_pend <= 1'b0;
         end
         if (ref_take) begin
            ref_pend <= 1'b0;
         end else if (tick_refresh && !burst_active) begin
            ref_pend <= 1'b1;
         end
         if (timeout_evt) begin
            err_timeout <= 1'b1;
         end else if (clr_err) begin
            err_timeout <= 1'b0;
         end
         if (pb_req && wr_pend) begin
            err_overrun <= 1'b1;
         end else if (clr_err) begin
            err_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arbitro_acceso_rtc.sv
// Self-checking bench for arbitro_acceso_rtc: a behavioural RTC engine plus scoreboards of
// expected bus transactions and register updates.
module tb_arbitro_acceso_rtc;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } txn_t;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] data;
   } upd_t;

   localparam int ENG_DELAY = 5;

   logic       clk;
   logic       reset;
   logic       tick_refresh;
   logic       pb_req;
   logic [7:0] pb_addr;
   logic [7:0] pb_data;
   logic       pb_busy;
   logic       rtc_req;
   logic       rtc_we;
   logic [7:0] rtc_addr;
   logic [7:0] rtc_wdata;
   logic       rtc_done;
   logic [7:0] rtc_rdata;
   logic       upd_valid;
   logic [3:0] upd_sel;
   logic [7:0] upd_data;
   logic       burst_active;
   logic       err_timeout;
   logic       err_overrun;
   logic       clr_err;

   logic [7:0] addr_tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

   txn_t exp_txn[$];
   upd_t exp_upd[$];
   int   n_checks      = 0;
   int   n_fail        = 0;
   int   cyc           = 0;
   int   txn_count     = 0;
   int   busy_cnt      = 0;
   int   hang_txn      = -1;
   int   last_done_cyc = -10;
   txn_t cur;

   arbitro_acceso_rtc dut (
      .clk          (clk),
      .reset        (reset),
      .tick_refresh (tick_refresh),
      .pb_req       (pb_req),
      .pb_addr      (pb_addr),
      .pb_data      (pb_data),
      .pb_busy      (pb_busy),
      .rtc_req      (rtc_req),
      .rtc_we       (rtc_we),
      .rtc_addr     (rtc_addr),
      .rtc_wdata    (rtc_wdata),
      .rtc_done     (rtc_done),
      .rtc_rdata    (rtc_rdata),
      .upd_valid    (upd_valid),
      .upd_sel      (upd_sel),
      .upd_data     (upd_data),
      .burst_active (burst_active),
      .err_timeout  (err_timeout),
      .err_overrun  (err_overrun),
      .clr_err      (clr_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Engine model: done ENG_DELAY cycles after each request, rdata = addr + 1.
   initial begin
      rtc_done  = 1'b0;
      rtc_rdata = 8'h00;
      forever begin
         @(negedge clk);
         rtc_done  = 1'b0;
         rtc_rdata = 8'($urandom);
         if (reset) begin
            busy_cnt = 0;
         end else begin
            if (busy_cnt > 0) begin
               busy_cnt--;
               if (busy_cnt == 0) begin
                  n_checks++;
                  if ({rtc_we, rtc_addr, rtc_wdata} !== cur)
                     $display("FAIL bus_stable: got %h required %h", {rtc_we, rtc_addr, rtc_wdata}, cur);
                  if ({rtc_we, rtc_addr, rtc_wdata} !== cur) n_fail++;
                  rtc_done      = 1'b1;
                  rtc_rdata     = cur.addr + 8'h01;
                  last_done_cyc = cyc;
               end
            end
            if (rtc_req) begin
               txn_count++;
               n_checks++;
               if (cyc == last_done_cyc + 1) begin
                  $display("FAIL turnaround: req at cycle %0d, done at cycle %0d", cyc, last_done_cyc);
                  n_fail++;
               end
               n_checks++;
               if (exp_txn.size() == 0) begin
                  $display("FAIL unexpected_txn: got we=%b addr=%h wdata=%h, none expected",
                           rtc_we, rtc_addr, rtc_wdata);
                  n_fail++;
               end else begin
                  txn_t e;
                  e = exp_txn.pop_front();
                  if (rtc_we !== e.we || rtc_addr !== e.addr || (e.we && rtc_wdata !== e.wdata)) begin
                     $display("FAIL txn: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                              rtc_we, rtc_addr, rtc_wdata, e.we, e.addr, e.wdata);
                     n_fail++;
                  end
               end
               cur      = {rtc_we, rtc_addr, rtc_wdata};
               busy_cnt = (txn_count == hang_txn) ? 0 : ENG_DELAY;
            end
         end
      end
   end

   // Update monitor: every upd_valid pulse must match the next expected register update.
   initial begin
      forever begin
         @(negedge clk);
         if (upd_valid === 1'b1) begin
            n_checks++;
            if (exp_upd.size() == 0) begin
               $display("FAIL unexpected_upd: got sel=%0d data=%h, none expected", upd_sel, upd_data);
               n_fail++;
            end else begin
               upd_t u;
               u = exp_upd.pop_front();
               if (upd_sel !== u.sel || upd_data !== u.data || burst_active !== (u.sel != 4'd8)) begin
                  $display("FAIL upd: got sel=%0d data=%h burst=%b required sel=%0d data=%h burst=%b",
                           upd_sel, upd_data, burst_active, u.sel, u.data, (u.sel != 4'd8));
                  n_fail++;
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse(input logic tick, input logic pb, input logic [7:0] a, input logic [7:0] d);
      tick_refresh = tick;
      pb_req       = pb;
      pb_addr      = a;
      pb_data      = d;
      step();
      tick_refresh = 1'b0;
      pb_req       = 1'b0;
   endtask

   task automatic push_read(input int i, input bit with_upd);
      exp_txn.push_back(txn_t'{1'b0, addr_tbl[i], 8'h00});
      if (with_upd) exp_upd.push_back(upd_t'{4'(i), addr_tbl[i] + 8'h01});
   endtask

   task automatic push_burst();
      exp_txn.push_back(txn_t'{1'b1, 8'hF0, 8'hF0});
      for (int i = 0; i < 9; i++) push_read(i, 1'b1);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (!(exp_txn.size() == 0 && exp_upd.size() == 0 && !burst_active && !pb_busy && busy_cnt == 0)
             && k < 3000) begin
         step();
         k++;
      end
      n_checks++;
      if (k >= 3000) begin
         $display("FAIL %s_drain: %0d txns and %0d updates still outstanding", name,
                  exp_txn.size(), exp_upd.size());
         n_fail++;
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      logic [34:0] outs;
      reset = 1'b1;
      repeat (2) step();
      outs = {pb_busy, rtc_req, rtc_we, rtc_addr, rtc_wdata, upd_valid, upd_sel, upd_data,
              burst_active, err_timeout, err_overrun};
      n_checks++;
      if (outs !== '0) begin
         $display("FAIL reset_outputs: got %h required 0", outs);
         n_fail++;
      end
      reset = 1'b0;
      repeat (3) step();
      n_checks++;
      if (rtc_req !== 1'b0 || pb_busy !== 1'b0 || burst_active !== 1'b0) begin
         $display("FAIL idle_after_reset: req=%b busy=%b burst=%b required 0", rtc_req, pb_busy, burst_active);
         n_fail++;
      end
   endtask

   task automatic test_idle_write();
      int k = 0;
      exp_txn.push_back(txn_t'{1'b1, 8'h22, 8'h45});
      pulse(1'b0, 1'b1, 8'h22, 8'h45);
      n_checks++;
      if (pb_busy !== 1'b1) begin
         $display("FAIL pb_busy_pending: got %b required 1", pb_busy);
         n_fail++;
      end
      while (rtc_done !== 1'b1 && k < 50) begin
         step();
         k++;
      end
      n_checks++;
      if (k >= 50 || pb_busy !== 1'b1) begin
         $display("FAIL pb_busy_at_done: waited %0d cycles, busy=%b required done and busy=1", k, pb_busy);
         n_fail++;
      end
      step();
      n_checks++;
      if (pb_busy !== 1'b0) begin
         $display("FAIL pb_busy_after_done: got %b required 0", pb_busy);
         n_fail++;
      end
      wait_idle("idle_write");
   endtask

   task automatic test_burst();
      push_burst();
      pulse(1'b1, 1'b0, 8'h00, 8'h00);
      step();
      n_checks++;
      if (burst_active !== 1'b1) begin
         $display("FAIL burst_start: got %b required 1", burst_active);
         n_fail++;
      end
      wait_idle("burst");
   endtask

   task automatic test_same_cycle();
      exp_txn.push_back(txn_t'{1'b1, 8'h30, 8'h12});
      push_burst();
      pulse(1'b1, 1'b1, 8'h30, 8'h12);
      n_checks++;
      if (pb_busy !== 1'b1 || err_overrun !== 1'b0) begin
         $display("FAIL same_cycle_latch: busy=%b overrun=%b required 1/0", pb_busy, err_overrun);
         n_fail++;
      end
      wait_idle("same_cycle");
   endtask

   task automatic test_deferred_write();
      int base = txn_count;
      int k = 0;
      push_burst();
      pulse(1'b1, 1'b0, 8'h00, 8'h00);
      while (txn_count < base + 4 && k < 200) begin
         step();
         k++;
      end
      n_checks++;
      if (k >= 200) begin
         $display("FAIL third_read_wait: only %0d txns issued, required %0d", txn_count - base, 4);
         n_fail++;
      end
      exp_txn.push_back(txn_t'{1'b1, 8'h23, 8'h08});
      pulse(1'b0, 1'b1, 8'h23, 8'h08);
      n_checks++;
      if (pb_busy !== 1'b1 || err_overrun !== 1'b0) begin
         $display("FAIL deferred_latch: busy=%b overrun=%b required 1/0", pb_busy, err_overrun);
         n_fail++;
      end
      repeat (3) step();
      n_checks++;
      if (burst_active !== 1'b1) begin
         $display("FAIL burst_still_active: got %b required 1", burst_active);
         n_fail++;
      end
      pulse(1'b0, 1'b1, 8'h55, 8'h66);
      n_checks++;
      if (err_overrun !== 1'b1) begin
         $display("FAIL overrun_set: got %b required 1", err_overrun);
         n_fail++;
      end
      wait_idle("deferred_write");
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_checks++;
      if (err_overrun !== 1'b0) begin
         $display("FAIL overrun_clear: got %b required 0", err_overrun);
         n_fail++;
      end
   endtask

   task automatic test_timeout();
      int base = txn_count;
      int k = 0;
      hang_txn = base + 3;
      exp_txn.push_back(txn_t'{1'b1, 8'hF0, 8'hF0});
      push_read(0, 1'b1);
      push_read(1, 1'b0);
      pulse(1'b1, 1'b0, 8'h00, 8'h00);
      while (txn_count < base + 3 && k < 200) begin
         step();
         k++;
      end
      k = 0;
      while (err_timeout !== 1'b1 && k < 1200) begin
         step();
         k++;
      end
      n_checks++;
      if (k != 1025) begin
         $display("FAIL timeout_latency: err_timeout after %0d cycles, required 1025", k);
         n_fail++;
      end
      n_checks++;
      if (burst_active !== 1'b0 || rtc_req !== 1'b0) begin
         $display("FAIL timeout_abort: burst=%b req=%b required 0/0", burst_active, rtc_req);
         n_fail++;
      end
      wait_idle("timeout");
      hang_txn = -1;
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      n_checks++;
      if (err_timeout !== 1'b0) begin
         $display("FAIL timeout_clear: got %b required 0", err_timeout);
         n_fail++;
      end
      push_burst();
      pulse(1'b1, 1'b0, 8'h00, 8'h00);
      wait_idle("post_timeout_burst");
      n_checks++;
      if (err_timeout !== 1'b0) begin
         $display("FAIL clean_burst_err: got %b required 0", err_timeout);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_burst();
      int base = txn_count;
      int k = 0;
      logic [34:0] outs;
      exp_txn.push_back(txn_t'{1'b1, 8'hF0, 8'hF0});
      for (int i = 0; i < 5; i++) push_read(i, i < 4);
      pulse(1'b1, 1'b0, 8'h00, 8'h00);
      while (txn_count < base + 6 && k < 200) begin
         step();
         k++;
      end
      repeat (2) step();
      reset = 1'b1;
      #1;
      outs = {pb_busy, rtc_req, rtc_we, rtc_addr, rtc_wdata, upd_valid, upd_sel, upd_data,
              burst_active, err_timeout, err_overrun};
      n_checks++;
      if (outs !== '0 || exp_txn.size() != 0 || exp_upd.size() != 0) begin
         $display("FAIL mid_burst_reset: outs=%h txns_left=%0d upds_left=%0d required 0/0/0",
                  outs, exp_txn.size(), exp_upd.size());
         n_fail++;
      end
      repeat (3) step();
      reset = 1'b0;
      repeat (2) step();
      push_burst();
      pulse(1'b1, 1'b0, 8'h00, 8'h00);
      wait_idle("restart_burst");
   endtask

   initial begin
      reset        = 1'b1;
      tick_refresh = 1'b0;
      pb_req       = 1'b0;
      pb_addr      = 8'h00;
      pb_data      = 8'h00;
      clr_err      = 1'b0;
      test_reset();
      test_idle_write();
      test_burst();
      test_same_cycle();
      test_deferred_write();
      test_timeout();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
